hybrid_branch_predictor: RTL and testbench

- Parametrised tournament predictor with a direct-mapped BTB; successor to the single fixed branch_predictor in the Chronos RV32I pipeline.
- IF stage queries it every cycle with the fetch PC; the result drives the PC mux and is carried down IF/ID and ID/EX.
- EX stage updates it with resolved outcomes.
- Combines a bimodal PHT, a gshare PHT and a chooser table, plus a speculative global history register with mispredict repair.

---
 rtl/chronos_bp_pkg.sv | 34 +++
 rtl/bp_counter_table.sv | 38 +++
 rtl/hybrid_branch_predictor.sv | 140 ++++++++++++++
 tb/tb_hybrid_branch_predictor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/chronos_bp_pkg.sv
// chronos_bp_pkg: shared types and helpers for the hybrid branch predictor.
//   ctr_t         - 2-bit saturating counter (SNT/WNT/WT/ST encodings)
//   CHOOSE_GSHARE - chooser value at or above which gshare is selected
//   sat_inc/dec   - saturating counter step functions
//   btb_entry_t   - BTB entry {valid, tag, target}; tag/target fields are
//                   sized for the widest supported XLEN and zero-extended.
package chronos_bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  localparam ctr_t CHOOSE_GSHARE = WT;

  localparam int BP_XLEN_MAX = 64;

  typedef struct packed {
    logic                   valid;
    logic [BP_XLEN_MAX-1:0] tag;
    logic [BP_XLEN_MAX-1:0] target;
  } btb_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: table of 2-bit saturating counters.
//   clk, rst            - clock, asynchronous active-low reset (all -> INIT)
//   rd_a_idx/rd_a_ctr   - combinational read port A
//   rd_b_idx/rd_b_ctr   - combinational read port B
//   wr_en/wr_idx/wr_taken - train one counter toward taken / not-taken
// Reads return the pre-write value in the cycle of a write.
module bp_counter_table
  import chronos_bp_pkg::*;
#(
  parameter int   DEPTH = 256,
  parameter ctr_t INIT  = WNT,
  localparam int  IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_a_idx,
  output logic [1:0]       rd_a_ctr,
  input  logic [IDX_W-1:0] rd_b_idx,
  output logic [1:0]       rd_b_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t ctr [DEPTH];

  assign rd_a_ctr = ctr[rd_a_idx];
  assign rd_b_ctr = ctr[rd_b_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= INIT;
    end else if (wr_en) begin
      ctr[wr_idx] <= wr_taken ? sat_inc(ctr[wr_idx]) : sat_dec(ctr[wr_idx]);
    end
  end

endmodule

// File: rtl/hybrid_branch_predictor.sv
// hybrid_branch_predictor: tournament (bimodal + gshare + chooser) direction
// predictor with a direct-mapped BTB and speculative global history.
//   clk, rst (async, active-low)
//   fetch_valid, fetch_pc                      - IF lookup (combinational)
//   pred_taken, pred_target, pred_hit, pred_ghr - prediction + GHR snapshot
//   upd_valid, upd_pc, upd_taken, upd_target,
//   upd_ghr, upd_mispredict                    - EX resolution / training
// Optional (macro CHRONOS_BP_STATS_EN): stat_lookups, stat_mispredicts,
// 32-bit saturating event counters.
module hybrid_branch_predictor
  import chronos_bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid,
  input  logic [XLEN-1:0]     fetch_pc,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic                pred_hit,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict
`ifdef CHRONOS_BP_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);

  logic [GHR_BITS-1:0]  ghr;
  btb_entry_t           btb [BTB_ENTRIES];

  logic [PHT_IDX_W-1:0] f_bim_idx, f_gsh_idx, u_bim_idx, u_gsh_idx;
  logic [BTB_IDX_W-1:0] f_btb_idx, u_btb_idx;
  ctr_t                 f_bim_ctr, f_gsh_ctr, f_cho_ctr, f_sel_ctr;
  ctr_t                 u_bim_ctr, u_gsh_ctr, cho_upd_ctr_unused;
  btb_entry_t           f_ent, u_ent;
  logic                 bim_ok, gsh_ok;
  logic                 unused_bits;

  // Lookup indexing (fetch side)
  assign f_bim_idx = fetch_pc[PHT_IDX_W+1:2];
  assign f_gsh_idx = f_bim_idx ^ PHT_IDX_W'(ghr);
  assign f_btb_idx = fetch_pc[BTB_IDX_W+1:2];

  // Training indexing (update side); gshare uses the GHR the branch saw
  assign u_bim_idx = upd_pc[PHT_IDX_W+1:2];
  assign u_gsh_idx = u_bim_idx ^ PHT_IDX_W'(upd_ghr);
  assign u_btb_idx = upd_pc[BTB_IDX_W+1:2];

  // Chooser trains only when exactly one component was right
  assign bim_ok = (u_bim_ctr[1] == upd_taken);
  assign gsh_ok = (u_gsh_ctr[1] == upd_taken);

  bp_counter_table #(.DEPTH(PHT_ENTRIES), .INIT(WNT)) u_bimodal (
    .clk(clk), .rst(rst),
    .rd_a_idx(f_bim_idx), .rd_a_ctr(f_bim_ctr),
    .rd_b_idx(u_bim_idx), .rd_b_ctr(u_bim_ctr),
    .wr_en(upd_valid), .wr_idx(u_bim_idx), .wr_taken(upd_taken)
  );

  bp_counter_table #(.DEPTH(PHT_ENTRIES), .INIT(WNT)) u_gshare (
    .clk(clk), .rst(rst),
    .rd_a_idx(f_gsh_idx), .rd_a_ctr(f_gsh_ctr),
    .rd_b_idx(u_gsh_idx), .rd_b_ctr(u_gsh_ctr),
    .wr_en(upd_valid), .wr_idx(u_gsh_idx), .wr_taken(upd_taken)
  );

  bp_counter_table #(.DEPTH(PHT_ENTRIES), .INIT(WNT)) u_chooser (
    .clk(clk), .rst(rst),
    .rd_a_idx(f_bim_idx), .rd_a_ctr(f_cho_ctr),
    .rd_b_idx(u_bim_idx), .rd_b_ctr(cho_upd_ctr_unused),
    .wr_en(upd_valid && (bim_ok != gsh_ok)), .wr_idx(u_bim_idx),
    .wr_taken(gsh_ok)
  );

  // Prediction: purely combinational from current state
  assign f_ent       = btb[f_btb_idx];
  assign pred_hit    = f_ent.valid &&
                       (f_ent.tag == BP_XLEN_MAX'(fetch_pc[XLEN-1:BTB_IDX_W+2]));
  assign f_sel_ctr   = (f_cho_ctr >= CHOOSE_GSHARE) ? f_gsh_ctr : f_bim_ctr;
  assign pred_taken  = pred_hit && f_sel_ctr[1];
  assign pred_target = pred_taken ? f_ent.target[XLEN-1:0] : fetch_pc + XLEN'(4);
  assign pred_ghr    = ghr;

  // Upper tag/target bits beyond XLEN and the byte offset of upd_pc are
  // structurally unused.
  assign unused_bits = ^{f_ent.target, upd_pc[1:0], cho_upd_ctr_unused};

  assign u_ent.valid  = 1'b1;
  assign u_ent.tag    = BP_XLEN_MAX'(upd_pc[XLEN-1:BTB_IDX_W+2]);
  assign u_ent.target = BP_XLEN_MAX'(upd_target);

  // BTB: taken branches allocate/overwrite; not-taken leaves entries alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
    end else if (upd_valid && upd_taken) begin
      btb[u_btb_idx] <= u_ent;
    end
  end

  // GHR: mispredict repair takes priority over the speculative shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (upd_valid && upd_mispredict) begin
      ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
    end else if (fetch_valid && pred_hit) begin
      ghr <= {ghr[GHR_BITS-2:0], pred_taken};
    end
  end

`ifdef CHRONOS_BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (fetch_valid && (stat_lookups != '1))
        stat_lookups <= stat_lookups + 32'd1;
      if (upd_valid && upd_mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// tb_hybrid_branch_predictor: directed self-checking bench for the hybrid
// branch predictor (default parameters). Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns after inputs settle.
module tb_hybrid_branch_predictor;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_ghr;
  logic        upd_mispredict;
`ifdef CHRONOS_BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
  int          n_lookups;
  int          n_mispredicts;
`endif

  int n_checks;
  int n_errors;

  hybrid_branch_predictor dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_hit(pred_hit), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr),
    .upd_mispredict(upd_mispredict)
`ifdef CHRONOS_BP_STATS_EN
    ,
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CHRONOS_BP_STATS_EN
  initial begin
    n_lookups = 0;
    n_mispredicts = 0;
  end
  always @(posedge clk) begin
    if (rst && fetch_valid) n_lookups++;
    if (rst && upd_valid && upd_mispredict) n_mispredicts++;
  end
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid    = 1'b0;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic [7:0] g, input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_ghr        = g;
    upd_mispredict = mis;
    tick();
    idle();
  endtask

  task automatic lookup(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    #1;
  endtask

  task automatic expect_pred(input string tag, input logic hit, input logic tk,
                             input logic [31:0] tgt);
    chk({tag, "_hit"},    64'(pred_hit),    64'(hit));
    chk({tag, "_taken"},  64'(pred_taken),  64'(tk));
    chk({tag, "_target"}, 64'(pred_target), 64'(tgt));
  endtask

  initial begin
    logic        outcome;
    logic        pred;
    logic [7:0]  g;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    fetch_pc = 32'h0;
    upd_pc = 32'h0;
    upd_taken = 1'b0;
    upd_target = 32'h0;
    upd_ghr = 8'h0;
    idle();

    // Reset asserted asynchronously; outputs while in reset
    #2 rst = 1'b0;
    lookup(32'h100);
    expect_pred("in_reset", 1'b0, 1'b0, 32'h104);
    chk("in_reset_ghr", 64'(pred_ghr), 64'h0);
    fetch_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Cold lookup
    lookup(32'h100);
    expect_pred("cold", 1'b0, 1'b0, 32'h104);
    chk("cold_ghr", 64'(pred_ghr), 64'h0);
    tick();
    idle();

    // Two taken updates -> BTB allocated, bimodal counter 1->3
    update(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
    update(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
    lookup(32'h100);
    expect_pred("trained", 1'b1, 1'b1, 32'h200);
    tick();
    idle();
    chk("ghr_spec_shift", 64'(pred_ghr), 64'h01);

    // Alias on BTB index 0 with a different tag
    lookup(32'h140);
    expect_pred("alias_miss", 1'b0, 1'b0, 32'h144);
    tick();
    idle();
    chk("ghr_no_shift_on_miss", 64'(pred_ghr), 64'h01);
    update(32'h140, 1'b1, 32'h300, 8'h00, 1'b0);
    lookup(32'h100);
    expect_pred("evicted", 1'b0, 1'b0, 32'h104);
    tick();
    lookup(32'h140);
    expect_pred("alias_hit", 1'b1, 1'b1, 32'h300);
    tick();
    idle();
    chk("ghr_after_alias", 64'(pred_ghr), 64'h03);

    // Saturation: counter already 3, five more taken, then one not-taken -> 2
    for (int i = 0; i < 5; i++) update(32'h100, 1'b1, 32'h200, 8'h00, 1'b0);
    update(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
    lookup(32'h100);
    expect_pred("sat_3to2", 1'b1, 1'b1, 32'h200);
    tick();
    idle();
    update(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
    lookup(32'h100);
    expect_pred("sat_2to1", 1'b1, 1'b0, 32'h104);
    chk("sat_ghr", 64'(pred_ghr), 64'h07);
    tick();
    idle();
    chk("sat_ghr_nt_shift", 64'(pred_ghr), 64'h0E);

    // Repair: set GHR to 0x03, then repair and a hitting fetch in one cycle
    update(32'h404, 1'b1, 32'h500, 8'h01, 1'b1);
    chk("repair_set", 64'(pred_ghr), 64'h03);
    upd_valid      = 1'b1;
    upd_pc         = 32'h408;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    upd_ghr        = 8'h05;
    upd_mispredict = 1'b1;
    lookup(32'h100);
    chk("repair_fetch_hit", 64'(pred_hit), 64'h1);
    chk("repair_pre_ghr", 64'(pred_ghr), 64'h03);
    tick();
    idle();
    chk("repair_wins", 64'(pred_ghr), 64'h0A);

    // Alternating T,N on one branch: gshare learns it, chooser moves to gshare
    for (int i = 0; i < 64; i++) begin
      outcome = (i % 2 == 0);
      lookup(32'h80C);
      pred = pred_taken;
      g    = pred_ghr;
      if (i >= 48) begin
        chk("alt_pred", 64'(pred_taken), 64'(outcome));
        chk("alt_target", 64'(pred_target), outcome ? 64'h900 : 64'h810);
        chk("alt_ghr", 64'(pred_ghr), outcome ? 64'hAA : 64'h55);
      end
      tick();
      idle();
      update(32'h80C, outcome, 32'h900, g, pred != outcome);
    end
    chk("chooser_ge2", 64'(dut.u_chooser.ctr[3] >= 2'd2), 64'h1);

`ifdef CHRONOS_BP_STATS_EN
    chk("stat_lookups", 64'(stat_lookups), 64'(n_lookups));
    chk("stat_mispredicts", 64'(stat_mispredicts), 64'(n_mispredicts));
`endif

    // Asynchronous reset in mid-cycle clears state immediately
    lookup(32'h80C);
    chk("pre_areset_hit", 64'(pred_hit), 64'h1);
    #2 rst = 1'b0;
    #1;
    expect_pred("areset", 1'b0, 1'b0, 32'h810);
    chk("areset_ghr", 64'(pred_ghr), 64'h0);
`ifdef CHRONOS_BP_STATS_EN
    chk("areset_stat", 64'(stat_lookups), 64'h0);
`endif
    idle();
    tick();
    rst = 1'b1;
    tick();
    lookup(32'h80C);
    expect_pred("post_reset", 1'b0, 1'b0, 32'h810);
    tick();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
